// File: rtl/aes_key_sched_ctrl.sv
// AES key-expansion sequencer: loads a 128/192/256-bit key, steps the shared
// word-expansion unit through its two-cycle SubWord pipeline and writes every round-key word.
module aes_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         we_sel0,
  output logic         we_sel1,
  output logic [31:0]  we_rcon,
  output logic [31:0]  we_old_w,
  output logic [31:0]  we_new_w,
  input  logic [31:0]  we_out_w,
  output logic         rk_we,
  output logic [5:0]   rk_addr,
  output logic [31:0]  rk_wdata
);

  localparam int DATA_W = 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  logic [2:0]        state;
  logic [1:0]        klen;
  logic [5:0]        idx;
  logic [2:0]        pos;
  logic [7:0]        rc;
  logic [DATA_W-1:0] win [8];

  logic [2:0] nk_m1;
  logic [5:0] last_idx;
  logic [2:0] pos_nx;
  logic       rcon_hvy;
  logic       sub_hvy;
  logic       nxt_hvy;
  logic       accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  always_comb begin
    case (klen)
      2'd1:    begin nk_m1 = 3'd5; last_idx = 6'd51; end
      2'd2:    begin nk_m1 = 3'd7; last_idx = 6'd59; end
      default: begin nk_m1 = 3'd3; last_idx = 6'd43; end
    endcase
  end

  // pos tracks i mod Nk so word classification needs no divider
  always_comb begin
    pos_nx   = (pos == nk_m1) ? 3'd0 : pos + 3'd1;
    rcon_hvy = (pos == 3'd0);
    sub_hvy  = (klen == 2'd2) && (pos == 3'd4);
    nxt_hvy  = (pos_nx == 3'd0) || ((klen == 2'd2) && (pos_nx == 3'd4));
    accept   = (state == S_IDLE) && start && (key_len != 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      klen  <= 2'd0;
      idx   <= 6'd0;
      pos   <= 3'd0;
      rc    <= 8'd0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            klen  <= key_len;
            idx   <= 6'd0;
            pos   <= 3'd0;
            rc    <= 8'h01;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          idx <= idx + 6'd1;
          pos <= pos_nx;
          if (pos == nk_m1) state <= nxt_hvy ? S_ISSUE : S_COMMIT;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT:  state <= S_COMMIT;
        S_COMMIT: begin
          idx <= idx + 6'd1;
          pos <= pos_nx;
          if (rcon_hvy) rc <= xtime(rc);
          if (idx == last_idx) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            state <= nxt_hvy ? S_ISSUE : S_COMMIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Window: win[0] = w[i-Nk], win[Nk-1] = w[i-1]; slots above Nk-1 are unused
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < 8; j++) win[j] <= key_in[32*j +: 32];
    end else if (state == S_COMMIT) begin
      for (int j = 0; j < 7; j++) win[j] <= win[j+1];
      win[nk_m1] <= we_out_w;
    end
  end

  always_comb begin
    busy     = (state != S_IDLE);
    we_sel0  = 1'b0;
    we_sel1  = 1'b0;
    we_rcon  = '0;
    we_old_w = '0;
    we_new_w = '0;
    rk_we    = 1'b0;
    rk_addr  = '0;
    rk_wdata = '0;
    case (state)
      S_LOAD: begin
        rk_we    = 1'b1;
        rk_addr  = idx;
        rk_wdata = win[idx[2:0]];
      end
      S_ISSUE, S_WAIT, S_COMMIT: begin
        we_old_w = win[0];
        we_new_w = win[nk_m1];
        we_sel0  = sub_hvy;
        we_rcon  = {24'h0, rc};
        if (state == S_COMMIT) begin
          we_sel1  = rcon_hvy || sub_hvy;
          rk_we    = 1'b1;
          rk_addr  = idx;
          rk_wdata = we_out_w;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequencer for the AES key-expansion word unit. It loads a 128/192/256-bit cipher key and drives the word-expansion datapath (select lines, Rcon, old/new words) through its two-cycle SubWord pipeline. It writes every round-key word, key words included, into the round-key RAM in order. It sits between the AES core's key-setup logic and the shared word-expansion unit, which it owns exclusively while busy.

## Interface
Parameters:
- None; the word width is fixed at 32 and the RAM address at 6 bits.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin an expansion; sampled only in IDLE.
- key_len  in  2  key size: 0 = AES-128 (Nk=4), 1 = AES-192 (Nk=6), 2 = AES-256 (Nk=8), 3 = reserved.
- key_in  in  256  key word j at key_in[32j+:32]; only words 0..Nk-1 are used.
- busy  out  1  high from the cycle after start is accepted until the last write.
- done  out  1  one-cycle pulse in the cycle after the last RAM write.
- we_sel0  out  1  to the expansion unit: 1 = SubWord only, 0 = SubWord(RotWord) ^ Rcon.
- we_sel1  out  1  to the expansion unit: 1 = use the pipelined SubWord result, 0 = new_w passes through.
- we_rcon  out  32  Rcon word {24'h0, rc}.
- we_old_w  out  32  w[i-Nk].
- we_new_w  out  32  w[i-1].
- we_out_w  in  32  combinational expansion result, w[i].
- rk_we  out  1  round-key RAM write enable.
- rk_addr  out  6  word index i.
- rk_wdata  out  32  w[i].

## Operation
- Byte order: byte 0 of each AES word is in bits [7:0]. The Rcon byte therefore sits in [7:0].
- Total word count T = 44, 52 or 60 for Nk = 4, 6 or 8.
- Window: 8x32 registers win[0..7].
  - win[0] = w[i-Nk] and win[Nk-1] = w[i-1].
  - On each expanded-word commit, the window shifts down by one and we_out_w is inserted at win[Nk-1].
- States: IDLE, LOAD, ISSUE, WAIT, COMMIT.
- IDLE:
  - Accepts start when key_len != 3: latches key_len, copies the Nk key words into win, sets i=0 and rc=8'h01, then goes to LOAD.
  - start with key_len == 3 is ignored.
  - start is ignored in every state other than IDLE.
- LOAD: one cycle per key word, with rk_we=1, rk_addr=i, rk_wdata=key word i.
  - After i = Nk-1, go to ISSUE if the next word is heavy, otherwise to COMMIT.
- Word i >= Nk is classified as follows:
  - Rcon-heavy when i mod Nk == 0: we_sel0=0.
  - Sub-heavy when Nk == 8 and i mod 8 == 4: we_sel0=1.
  - Light otherwise.
- Heavy words take ISSUE -> WAIT -> COMMIT.
  - we_new_w, we_old_w, we_sel0 and we_rcon are held stable in all three states.
  - we_sel1 = 1 in COMMIT only.
- Light words take COMMIT only, with we_sel1=0.
- COMMIT: rk_we=1, rk_wdata=we_out_w, rk_addr=i; then i increments and the window shifts.
  - After an Rcon-heavy commit, rc <= xtime(rc): shift left, XOR 8'h1b if bit 7 was set. This gives 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - If i == T-1, go to IDLE and pulse done; otherwise go to the next word's first state.
- Outputs outside LOAD and COMMIT: rk_we=0.
- Outputs in IDLE: we_sel0=0, we_sel1=0, we_rcon=0, we_old_w=0, we_new_w=0.

## Timing
- Reset values: busy=0, done=0, rk_we=0, rk_addr=0, rk_wdata=0, all we_* outputs 0, state=IDLE.
- Reset mid-operation: the block returns to IDLE on the next edge and issues no further writes. Window contents are don't-care.
- Cycle 0 is the cycle in which start is sampled in IDLE.
  - Load writes occur in cycles 1..Nk.
  - busy is high from cycle 1 through the last write cycle.
- Expansion-unit contract:
  - The SBox output is registered, valid one cycle after the address.
  - sel0_result is registered one cycle after that.
  - ISSUE at cycle t therefore produces a valid out_w in COMMIT at cycle t+2.
- Last write cycle / done cycle per key size:
  - AES-128: 64 / 65 (10 heavy, 30 light).
  - AES-192: 68 / 69 (8 heavy, 38 light).
  - AES-256: 86 / 87 (13 heavy, 39 light).
- Exactly T rk_we pulses occur per run, with rk_addr strictly 0..T-1 in order.
- done and start in the same cycle: the block is back in IDLE in the done cycle, so start is accepted there and the new run starts on the following edge.

## Test plan
- FIPS-197 AES-128 key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> w4 = a0fafe17, w43 = b6630ca6; 44 writes; done in cycle 65. Words are given in FIPS byte order, so a0 is bits [7:0].
- FIPS-197 AES-192 key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> w6 = fe0c91f7, w51 = 01002202; done in cycle 69.
- FIPS-197 AES-256 key 603deb10 ... 0914dff4 -> w8 = 9ba35411, w12 = a8b09c1a (we_sel0=1 in ISSUE), w59 = 706c631e; done in cycle 87.
- start pulsed during busy, and start with key_len=3 in IDLE -> no change in state or write sequence; busy stays 0 in the key_len=3 case.
- rst asserted at cycle 30 of an AES-256 run -> busy=0 and rk_we=0 from cycle 31, no done pulse. A following AES-128 start reproduces the vectors above with rc restarting at 01.
- Back-to-back runs: start held high continuously -> a second run begins in the cycle after done, with identical write ordering.
